// File: rtl/vu_pkg.sv
// Shared types and constants for the stereo VU level detector.
package vu_pkg;

    typedef enum logic [1:0] {VU_IDLE, VU_ATTACK, VU_HOLD, VU_DECAY} vu_state_t;

    localparam logic [7:0]  VU_LEVEL_ZERO = 8'h80;
    localparam int unsigned VU_ENV_W      = 16;

    // Meter code is offset-binary: the driver inverts the MSB to recover the unsigned level.
    function automatic logic [7:0] vu_encode(input logic [VU_ENV_W-1:0] env);
        return {~env[VU_ENV_W-1], env[VU_ENV_W-2 -: 7]};
    endfunction

endpackage

// File: rtl/vu_envelope_channel.sv
// One channel of the VU envelope follower: rectify, attack/hold/decay ballistics, level output.
module vu_envelope_channel
    import vu_pkg::*;
#(
    parameter int unsigned SAMPLE_W     = 24,
    parameter int unsigned ATTACK_SHIFT = 2,
    parameter int unsigned DECAY_SHIFT  = 6,
    parameter int unsigned HOLD_SAMPLES = 4800
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                audio_enable,
    input  logic                data_en,
    input  logic [SAMPLE_W-1:0] audio_data,
    output logic                level_en,
    output logic [7:0]          vu_signal
);

    localparam logic [SAMPLE_W-1:0] MOST_NEG    = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] MOST_POS    = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [15:0]         HOLD_RELOAD = 16'(HOLD_SAMPLES - 1);

    logic [SAMPLE_W-1:0] abs_val;
    logic                s1_valid_q;
    logic [VU_ENV_W-1:0] mag_q;
    logic [VU_ENV_W-1:0] env_q;
    logic [15:0]         hold_q;
    vu_state_t           state_q;

    logic                rising;
    logic [VU_ENV_W:0]   diff;
    logic [VU_ENV_W:0]   rise_step;
    logic [VU_ENV_W-1:0] fall_step;
    logic [VU_ENV_W-1:0] env_rise;
    logic [VU_ENV_W-1:0] env_fall;
    logic                unused_bits;

    // Full-scale negative has no positive twin, so it saturates instead of wrapping.
    always_comb begin
        if (audio_data == MOST_NEG) begin
            abs_val = MOST_POS;
        end else if (audio_data[SAMPLE_W-1]) begin
            abs_val = ~audio_data + SAMPLE_W'(1);
        end else begin
            abs_val = audio_data;
        end
    end

    assign unused_bits = ^{abs_val[SAMPLE_W-1], abs_val[SAMPLE_W-VU_ENV_W-2:0],
                           rise_step[VU_ENV_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            mag_q      <= '0;
        end else begin
            s1_valid_q <= data_en && audio_enable;
            if (data_en) begin
                mag_q <= abs_val[SAMPLE_W-2 -: VU_ENV_W];
            end
        end
    end

    always_comb begin
        rising    = mag_q > env_q;
        diff      = {1'b0, mag_q} - {1'b0, env_q};
        rise_step = diff >> ATTACK_SHIFT;
        if (rise_step == '0) begin
            rise_step = (VU_ENV_W + 1)'(1);
        end
        env_rise  = env_q + rise_step[VU_ENV_W-1:0];
        fall_step = env_q >> DECAY_SHIFT;
        if (fall_step == '0) begin
            fall_step = VU_ENV_W'(1);
        end
        env_fall  = (env_q > fall_step) ? env_q - fall_step : '0;
    end

    // Envelope FSM and output register share one edge so level_en lands two clocks after data_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= VU_IDLE;
            env_q     <= '0;
            hold_q    <= '0;
            level_en  <= 1'b0;
            vu_signal <= VU_LEVEL_ZERO;
        end else if (!audio_enable) begin
            state_q   <= VU_IDLE;
            env_q     <= '0;
            hold_q    <= '0;
            level_en  <= 1'b0;
            vu_signal <= VU_LEVEL_ZERO;
        end else begin
            level_en <= s1_valid_q;
            if (s1_valid_q) begin
                if (rising) begin
                    state_q   <= VU_ATTACK;
                    env_q     <= env_rise;
                    vu_signal <= vu_encode(env_rise);
                end else begin
                    vu_signal <= vu_encode(env_q);
                    unique case (state_q)
                        VU_IDLE: begin
                        end
                        VU_ATTACK: begin
                            hold_q  <= HOLD_RELOAD;
                            state_q <= VU_HOLD;
                        end
                        VU_HOLD: begin
                            if (hold_q == '0) begin
                                state_q <= VU_DECAY;
                            end else begin
                                hold_q <= hold_q - 16'd1;
                            end
                        end
                        VU_DECAY: begin
                            env_q     <= env_fall;
                            vu_signal <= vu_encode(env_fall);
                            if (env_fall == '0) begin
                                state_q <= VU_IDLE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/vu_level_detector.sv
// Stereo VU envelope follower; two independent channel pipelines feeding the meter PWM driver.
module vu_level_detector #(
    parameter int unsigned SAMPLE_W     = 24,
    parameter int unsigned ATTACK_SHIFT = 2,
    parameter int unsigned DECAY_SHIFT  = 6,
    parameter int unsigned HOLD_SAMPLES = 4800
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                audio_enable,
    input  logic                l_data_en,
    input  logic                r_data_en,
    input  logic [SAMPLE_W-1:0] l_audio_data,
    input  logic [SAMPLE_W-1:0] r_audio_data,
    output logic                l_level_en,
    output logic                r_level_en,
    output logic [7:0]          l_vu_signal,
    output logic [7:0]          r_vu_signal
);

    vu_envelope_channel #(
        .SAMPLE_W     (SAMPLE_W),
        .ATTACK_SHIFT (ATTACK_SHIFT),
        .DECAY_SHIFT  (DECAY_SHIFT),
        .HOLD_SAMPLES (HOLD_SAMPLES)
    ) u_left (
        .clk          (clk),
        .rst_n        (rst_n),
        .audio_enable (audio_enable),
        .data_en      (l_data_en),
        .audio_data   (l_audio_data),
        .level_en     (l_level_en),
        .vu_signal    (l_vu_signal)
    );

    vu_envelope_channel #(
        .SAMPLE_W     (SAMPLE_W),
        .ATTACK_SHIFT (ATTACK_SHIFT),
        .DECAY_SHIFT  (DECAY_SHIFT),
        .HOLD_SAMPLES (HOLD_SAMPLES)
    ) u_right (
        .clk          (clk),
        .rst_n        (rst_n),
        .audio_enable (audio_enable),
        .data_en      (r_data_en),
        .audio_data   (r_audio_data),
        .level_en     (r_level_en),
        .vu_signal    (r_vu_signal)
    );

endmodule

// File: tb/tb_vu_level_detector.sv
// Directed self-checking bench for vu_level_detector with a short hold time.
module tb_vu_level_detector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        audio_enable;
    logic        l_data_en;
    logic        r_data_en;
    logic [23:0] l_audio_data;
    logic [23:0] r_audio_data;
    logic        l_level_en;
    logic        r_level_en;
    logic [7:0]  l_vu_signal;
    logic [7:0]  r_vu_signal;

    int checks = 0;
    int errors = 0;
    int env_m;

    vu_level_detector #(
        .SAMPLE_W     (24),
        .ATTACK_SHIFT (2),
        .DECAY_SHIFT  (6),
        .HOLD_SAMPLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .audio_enable (audio_enable),
        .l_data_en    (l_data_en),
        .r_data_en    (r_data_en),
        .l_audio_data (l_audio_data),
        .r_audio_data (r_audio_data),
        .l_level_en   (l_level_en),
        .r_level_en   (r_level_en),
        .l_vu_signal  (l_vu_signal),
        .r_vu_signal  (r_vu_signal)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] vu_of(input int e);
        logic [15:0] v;
        v = e[15:0];
        return {~v[15], v[14:8]};
    endfunction

    function automatic int decay_next(input int e);
        int s;
        s = e >> 6;
        if (s < 1) s = 1;
        return (e > s) ? e - s : 0;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; one strobe, result expected two rising edges later.
    task automatic sample(input bit ch, input logic [23:0] d, input logic [7:0] exp,
                          input string tag);
        if (ch) begin
            r_data_en    = 1'b1;
            r_audio_data = d;
        end else begin
            l_data_en    = 1'b1;
            l_audio_data = d;
        end
        @(negedge clk);
        l_data_en = 1'b0;
        r_data_en = 1'b0;
        check({tag, "_early"}, ch ? r_level_en : l_level_en, 8'h00);
        @(negedge clk);
        check({tag, "_en"}, ch ? r_level_en : l_level_en, 8'h01);
        check({tag, "_vu"}, ch ? r_vu_signal : l_vu_signal, exp);
        check({tag, "_other_en"}, ch ? l_level_en : r_level_en, 8'h00);
    endtask

    task automatic attack_to(input bit ch, input logic [23:0] d, input int mag, input string tag);
        int step;
        while (env_m < mag) begin
            step = (mag - env_m) >> 2;
            if (step < 1) step = 1;
            env_m += step;
            sample(ch, d, vu_of(env_m), tag);
        end
        sample(ch, d, vu_of(env_m), {tag, "_peak"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        audio_enable = 1'b1;
        l_data_en    = 1'b0;
        r_data_en    = 1'b0;
        l_audio_data = '0;
        r_audio_data = '0;

        // 1: reset holds outputs idle even with strobes toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            l_data_en    = ~l_data_en;
            r_data_en    = ~r_data_en;
            l_audio_data = 24'h7FFFFF;
            r_audio_data = 24'h7FFFFF;
            check("rst_l_vu", l_vu_signal, 8'h80);
            check("rst_r_vu", r_vu_signal, 8'h80);
            check("rst_l_en", l_level_en, 8'h00);
            check("rst_r_en", r_level_en, 8'h00);
        end
        @(negedge clk);
        l_data_en = 1'b0;
        r_data_en = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("rel_l_vu", l_vu_signal, 8'h80);
        check("rel_l_en", l_level_en, 8'h00);
        @(negedge clk);
        check("rel_l_en2", l_level_en, 8'h00);

        // 2: full-scale positive attack; first level is BF, right untouched
        env_m = 0;
        attack_to(1'b0, 24'h7FFFFF, 32'hFFFF, "attack");
        check("attack_final", l_vu_signal, 8'h7F);
        check("attack_r_vu", r_vu_signal, 8'h80);

        // clear via audio_enable
        audio_enable = 1'b0;
        @(negedge clk);
        check("clear_vu", l_vu_signal, 8'h80);
        check("clear_en", l_level_en, 8'h00);
        audio_enable = 1'b1;

        // 3: most-negative input saturates to the same sequence
        env_m = 0;
        attack_to(1'b0, 24'h800000, 32'hFFFF, "sat");
        check("sat_final", l_vu_signal, 8'h7F);

        // 4: hold 8 samples at peak, then decay to idle
        for (int i = 0; i < 8; i++) sample(1'b0, 24'h000000, 8'h7F, "hold");
        sample(1'b0, 24'h000000, 8'h7C, "decay_first");
        env_m = 16'hFC00;
        while (env_m > 0) begin
            env_m = decay_next(env_m);
            sample(1'b0, 24'h000000, vu_of(env_m), "decay");
        end
        sample(1'b0, 24'h000000, 8'h80, "idle_stay");

        // 5: re-attack mid-hold, hold counter reloads afterwards
        env_m = 0;
        attack_to(1'b0, 24'h400000, 32'h8000, "mid_attack");
        for (int i = 0; i < 3; i++) sample(1'b0, 24'h000000, 8'h00, "mid_hold");
        sample(1'b0, 24'h7FFFFF, 8'h1F, "reattack");
        for (int i = 0; i < 9; i++) sample(1'b0, 24'h000000, 8'h1F, "rehold");
        sample(1'b0, 24'h000000, 8'h1D, "redecay");

        // 6a: drop audio_enable with a sample in flight
        l_data_en    = 1'b1;
        l_audio_data = 24'h000000;
        @(negedge clk);
        l_data_en    = 1'b0;
        audio_enable = 1'b0;
        @(negedge clk);
        check("drop_en", l_level_en, 8'h00);
        check("drop_vu", l_vu_signal, 8'h80);
        l_data_en    = 1'b1;
        l_audio_data = 24'h7FFFFF;
        @(negedge clk);
        l_data_en = 1'b0;
        @(negedge clk);
        check("ign_en", l_level_en, 8'h00);
        @(negedge clk);
        check("ign_en2", l_level_en, 8'h00);
        check("ign_vu", l_vu_signal, 8'h80);
        audio_enable = 1'b1;
        @(negedge clk);
        check("ign_en3", l_level_en, 8'h00);

        // 6b: back-to-back simultaneous strobes on both channels
        env_m        = 0;
        l_data_en    = 1'b1;
        r_data_en    = 1'b1;
        l_audio_data = 24'h400000;
        r_audio_data = 24'h000000;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            env_m = env_m + (((32'h8000 - env_m) >> 2) < 1 ? 1 : ((32'h8000 - env_m) >> 2));
            check("b2b_l_en", l_level_en, 8'h01);
            check("b2b_l_vu", l_vu_signal, vu_of(env_m));
            check("b2b_r_en", r_level_en, 8'h01);
            check("b2b_r_vu", r_vu_signal, 8'h80);
            @(negedge clk);
        end
        l_data_en = 1'b0;
        r_data_en = 1'b0;
        repeat (3) @(negedge clk);

        // right channel negative input
        sample(1'b1, 24'hC00000, 8'hA0, "r_neg");

        // reset asserted mid-pipeline clears immediately
        l_data_en    = 1'b1;
        l_audio_data = 24'h7FFFFF;
        @(negedge clk);
        l_data_en = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("mid_rst_l_vu", l_vu_signal, 8'h80);
        check("mid_rst_r_vu", r_vu_signal, 8'h80);
        check("mid_rst_l_en", l_level_en, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_en", l_level_en, 8'h00);
        @(negedge clk);
        check("post_rst_en2", l_level_en, 8'h00);
        check("post_rst_vu", l_vu_signal, 8'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
